cr_tcipif_initiator: RTL and testbench
======================================

# cr_tcipif_initiator

Initiator end of the tightly coupled IP interface (TCIPIF). It accepts single word-sized load/store requests from the core LSU, decodes the CLINT address window, and drives one TCIPIF transfer (sel/addr/write/wdata). It holds that transfer until the responder signals complete, then returns read data or an error to the LSU. The block sits in the core, between the LSU and the CLINT bus interface.

## Interface
Parameters:
- CLINT_BASE, 32'hE000_0000, base of the 64 KB CLINT window; only bits [31:16] are compared.
- TIMEOUT, 16, maximum number of sel-high cycles without complete. Used only with the timeout feature (see Configuration).

Ports:
- forever_cpuclk  in  1  clock; all state updates on the rising edge.
- cpurst_b  in  1  asynchronous reset, active-low.
- lsu_tcipif_req  in  1  request valid; sampled only while tcipif_lsu_ready=1.
- lsu_tcipif_addr  in  32  byte address.
- lsu_tcipif_write  in  1  1=store, 0=load.
- lsu_tcipif_wdata  in  32  store data.
- lsu_tcipif_size  in  2  0=byte, 1=half, 2=word.
- tcipif_lsu_ready  out  1  block idle, can accept a request.
- tcipif_lsu_cmplt  out  1  one-cycle response pulse.
- tcipif_lsu_rdata  out  32  load data; valid with cmplt.
- tcipif_lsu_error  out  1  access error; valid with cmplt.
- tcipif_clint_sel  out  1  transfer select.
- tcipif_clint_addr  out  16  CLINT offset (lsu addr[15:0]).
- tcipif_clint_write  out  1  transfer direction.
- tcipif_clint_wdata  out  32  transfer write data.
- clint_tcipif_cmplt  in  1  responder complete.
- clint_tcipif_rdata  in  32  responder read data; valid with complete.

## Operation
- FSM states: IDLE, REQ, RESP. All outputs are registered or decoded from registered state.
- Output values in reset and IDLE after reset:
  - ready=1.
  - sel=0, cmplt=0, error=0.
  - rdata=0, clint addr/write/wdata=0.
- IDLE, req=1:
  - Latch addr[15:0], write and wdata.
  - Evaluate decode error. It is set when any of these holds: addr[31:16]≠CLINT_BASE[31:16]; size≠2; addr[1:0]≠0.
  - Error → RESP with error=1 and rdata=0. No TCIPIF transfer is issued.
  - No error → REQ.
- REQ:
  - sel=1. clint addr/write/wdata are held stable for the whole state.
  - On clint_tcipif_cmplt=1: capture rdata (load) or 0 (store), error=0, go to RESP.
  - Otherwise stay in REQ with sel held high.
- RESP:
  - tcipif_lsu_cmplt=1 for exactly one cycle, with rdata and error.
  - Next state is IDLE. rdata and error clear to 0 in IDLE.
- ready=1 only in IDLE. A req while ready=0 is ignored; the LSU holds req until ready.
- clint addr/write/wdata keep their last values in IDLE. sel is the only qualifier.
- clint_tcipif_cmplt outside REQ is ignored.

## Timing
- Zero-wait responder (complete in the same cycle as sel):
  - Cycle 0: req accepted.
  - Cycle 1: sel=1.
  - Cycle 2: tcipif_lsu_cmplt=1.
  - Cycle 3: ready=1.
- Responder with N wait cycles: sel is high for N+1 cycles, and cmplt follows one cycle after the complete cycle.
- Decode error: cmplt in cycle 1, ready in cycle 2, sel never asserted.
- Back-to-back requests: minimum spacing is 3 cycles (error case 2).
- Asynchronous reset in any state: immediately IDLE, sel=0, cmplt=0. A pending transfer is dropped with no response.

## Configuration
- CR_TCIPIF_TIMEOUT_EN defined:
  - A cycle counter, clog2(TIMEOUT+1) bits, is cleared on entry to REQ and increments each REQ cycle without complete.
  - When the counter reaches TIMEOUT-1 with no complete: sel drops, go to RESP with error=1 and rdata=0.
  - Complete in that same final cycle wins (normal response, error=0).
- CR_TCIPIF_TIMEOUT_EN undefined: no counter; REQ waits indefinitely for complete.

## Test plan
- Load 0xE000_BFF8 size 2, responder returns 0x1234_5678 with complete in the sel cycle → sel in cycle 1 with addr 16'hBFF8 and write=0; cmplt in cycle 2 with rdata 0x1234_5678 and error=0.
- Store 0xE000_4000 wdata 0xDEAD_BEEF → cycle 1: sel=1, write=1, addr 16'h4000, wdata 0xDEAD_BEEF. Cycle 2: cmplt with rdata=0 and error=0.
- Load 0xE001_0000; then load 0xE000_0002 size 2; then store 0xE000_0000 size 0 → each: sel never asserted, cmplt in cycle 1 with error=1.
- Responder delays complete by 3 cycles → sel high for 4 cycles with stable addr/wdata; cmplt 1 cycle later. A req asserted during REQ is ignored and accepted once ready=1.
- With CR_TCIPIF_TIMEOUT_EN and TIMEOUT=16, responder never completes → sel high for 16 cycles, then cmplt with error=1 and rdata=0. Without the macro, sel stays high indefinitely.
- Assert cpurst_b=0 in REQ cycle 2 of a delayed transfer → sel=0 and ready=1 immediately, no cmplt. After release, a normal load completes correctly.

Source files
------------

// File: rtl/cr_tcipif_initiator.sv
// rtl/cr_tcipif_initiator.sv - TCIPIF initiator bridging single LSU requests to CLINT transfers
// Optional REQ timeout is enabled by defining CR_TCIPIF_TIMEOUT_EN.
module cr_tcipif_initiator #(
  parameter logic [31:0] CLINT_BASE = 32'hE000_0000,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        lsu_tcipif_req,
  input  logic [31:0] lsu_tcipif_addr,
  input  logic        lsu_tcipif_write,
  input  logic [31:0] lsu_tcipif_wdata,
  input  logic [1:0]  lsu_tcipif_size,
  output logic        tcipif_lsu_ready,
  output logic        tcipif_lsu_cmplt,
  output logic [31:0] tcipif_lsu_rdata,
  output logic        tcipif_lsu_error,
  output logic        tcipif_clint_sel,
  output logic [15:0] tcipif_clint_addr,
  output logic        tcipif_clint_write,
  output logic [31:0] tcipif_clint_wdata,
  input  logic        clint_tcipif_cmplt,
  input  logic [31:0] clint_tcipif_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        sel_q;
  logic        cmplt_q;
  logic        error_q;
  logic        write_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        decode_err;

  // Only aligned word accesses inside the 64 KB CLINT window are forwarded.
  assign decode_err = (lsu_tcipif_addr[31:16] != CLINT_BASE[31:16]) ||
                      (lsu_tcipif_size != 2'd2) ||
                      (lsu_tcipif_addr[1:0] != 2'b00);

`ifdef CR_TCIPIF_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      cmplt_q <= 1'b0;
      error_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 16'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
`ifdef CR_TCIPIF_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cmplt_q <= 1'b0;
          error_q <= 1'b0;
          rdata_q <= 32'h0;
          if (lsu_tcipif_req) begin
            addr_q  <= lsu_tcipif_addr[15:0];
            write_q <= lsu_tcipif_write;
            wdata_q <= lsu_tcipif_wdata;
            if (decode_err) begin
              state_q <= RESP;
              cmplt_q <= 1'b1;
              error_q <= 1'b1;
            end else begin
              state_q <= REQ;
              sel_q   <= 1'b1;
`ifdef CR_TCIPIF_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (clint_tcipif_cmplt) begin
            state_q <= RESP;
            sel_q   <= 1'b0;
            cmplt_q <= 1'b1;
            error_q <= 1'b0;
            rdata_q <= write_q ? 32'h0 : clint_tcipif_rdata;
`ifdef CR_TCIPIF_TIMEOUT_EN
          end else if (cnt_q == CNT_LAST) begin
            state_q <= RESP;
            sel_q   <= 1'b0;
            cmplt_q <= 1'b1;
            error_q <= 1'b1;
            rdata_q <= 32'h0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        RESP: begin
          state_q <= IDLE;
          cmplt_q <= 1'b0;
          error_q <= 1'b0;
          rdata_q <= 32'h0;
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= 1'b0;
          cmplt_q <= 1'b0;
          error_q <= 1'b0;
          rdata_q <= 32'h0;
        end
      endcase
    end
  end

  assign tcipif_lsu_ready   = (state_q == IDLE);
  assign tcipif_lsu_cmplt   = cmplt_q;
  assign tcipif_lsu_rdata   = rdata_q;
  assign tcipif_lsu_error   = error_q;
  assign tcipif_clint_sel   = sel_q;
  assign tcipif_clint_addr  = addr_q;
  assign tcipif_clint_write = write_q;
  assign tcipif_clint_wdata = wdata_q;

endmodule

// File: tb/tb_cr_tcipif_initiator.sv
// tb/tb_cr_tcipif_initiator.sv - directed self-checking bench for cr_tcipif_initiator
module tb_cr_tcipif_initiator;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        wr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        ready;
  logic        cmplt;
  logic [31:0] rdata;
  logic        error;
  logic        sel;
  logic [15:0] c_addr;
  logic        c_write;
  logic [31:0] c_wdata;
  logic        c_cmplt;
  logic [31:0] c_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  cr_tcipif_initiator #(.CLINT_BASE(32'hE000_0000), .TIMEOUT(16)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_n),
    .lsu_tcipif_req     (req),
    .lsu_tcipif_addr    (addr),
    .lsu_tcipif_write   (wr),
    .lsu_tcipif_wdata   (wdata),
    .lsu_tcipif_size    (size),
    .tcipif_lsu_ready   (ready),
    .tcipif_lsu_cmplt   (cmplt),
    .tcipif_lsu_rdata   (rdata),
    .tcipif_lsu_error   (error),
    .tcipif_clint_sel   (sel),
    .tcipif_clint_addr  (c_addr),
    .tcipif_clint_write (c_write),
    .tcipif_clint_wdata (c_wdata),
    .clint_tcipif_cmplt (c_cmplt),
    .clint_tcipif_rdata (c_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lsu(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [1:0] s);
    req   = 1'b1;
    addr  = a;
    wr    = w;
    wdata = d;
    size  = s;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = '0; wr = 1'b0; wdata = '0; size = 2'd2;
    c_cmplt = 1'b0; c_rdata = '0;
    #3;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_sel",   32'(sel),   32'd0);
    chk("rst_cmplt", 32'(cmplt), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rdata", rdata,      32'd0);
    chk("rst_caddr", 32'(c_addr), 32'd0);
    chk("rst_cwr",   32'(c_write), 32'd0);
    chk("rst_cwd",   c_wdata,    32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // zero-wait load
    lsu(32'hE000_BFF8, 1'b0, 32'h0, 2'd2);
    tick();
    req = 1'b0;
    chk("ld_sel",   32'(sel),     32'd1);
    chk("ld_ready", 32'(ready),   32'd0);
    chk("ld_caddr", 32'(c_addr),  32'h0000_BFF8);
    chk("ld_cwr",   32'(c_write), 32'd0);
    c_cmplt = 1'b1; c_rdata = 32'h1234_5678;
    tick();
    c_cmplt = 1'b0; c_rdata = 32'h0;
    chk("ld_cmplt", 32'(cmplt), 32'd1);
    chk("ld_rdata", rdata,      32'h1234_5678);
    chk("ld_err",   32'(error), 32'd0);
    chk("ld_sel_off", 32'(sel), 32'd0);
    tick();
    chk("ld_ready_back", 32'(ready), 32'd1);
    chk("ld_cmplt_off",  32'(cmplt), 32'd0);
    chk("ld_rdata_clr",  rdata,      32'd0);

    // zero-wait store; responder data must not leak into the store response
    lsu(32'hE000_4000, 1'b1, 32'hDEAD_BEEF, 2'd2);
    tick();
    req = 1'b0;
    chk("st_sel",   32'(sel),     32'd1);
    chk("st_cwr",   32'(c_write), 32'd1);
    chk("st_caddr", 32'(c_addr),  32'h0000_4000);
    chk("st_cwd",   c_wdata,      32'hDEAD_BEEF);
    c_cmplt = 1'b1; c_rdata = 32'h5555_AAAA;
    tick();
    c_cmplt = 1'b0;
    chk("st_cmplt", 32'(cmplt), 32'd1);
    chk("st_rdata", rdata,      32'd0);
    chk("st_err",   32'(error), 32'd0);
    tick();
    chk("st_ready", 32'(ready), 32'd1);

    // decode errors: out of window, misaligned, sub-word
    lsu(32'hE001_0000, 1'b0, 32'h0, 2'd2);
    tick();
    req = 1'b0;
    chk("e1_sel",   32'(sel),   32'd0);
    chk("e1_cmplt", 32'(cmplt), 32'd1);
    chk("e1_err",   32'(error), 32'd1);
    chk("e1_rdata", rdata,      32'd0);
    tick();
    chk("e1_ready", 32'(ready), 32'd1);
    chk("e1_err_clr", 32'(error), 32'd0);

    lsu(32'hE000_0002, 1'b0, 32'h0, 2'd2);
    tick();
    req = 1'b0;
    chk("e2_sel",   32'(sel),   32'd0);
    chk("e2_cmplt", 32'(cmplt), 32'd1);
    chk("e2_err",   32'(error), 32'd1);
    tick();
    chk("e2_ready", 32'(ready), 32'd1);

    lsu(32'hE000_0000, 1'b1, 32'h1111_2222, 2'd0);
    tick();
    req = 1'b0;
    chk("e3_sel",   32'(sel),   32'd0);
    chk("e3_cmplt", 32'(cmplt), 32'd1);
    chk("e3_err",   32'(error), 32'd1);
    // stray responder complete outside REQ is ignored
    c_cmplt = 1'b1; c_rdata = 32'hFFFF_FFFF;
    tick();
    chk("e3_ready", 32'(ready), 32'd1);
    tick();
    c_cmplt = 1'b0;
    chk("stray_cmplt", 32'(cmplt), 32'd0);
    chk("stray_sel",   32'(sel),   32'd0);

    // store with 3 wait cycles; a new load is held by the LSU during REQ
    lsu(32'hE000_0100, 1'b1, 32'hA5A5_5A5A, 2'd2);
    tick();
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dly_sel%0d", i),   32'(sel),    32'd1);
      chk($sformatf("dly_caddr%0d", i), 32'(c_addr), 32'h0000_0100);
      chk($sformatf("dly_cwd%0d", i),   c_wdata,     32'hA5A5_5A5A);
      if (i == 0) lsu(32'hE000_0010, 1'b0, 32'h0, 2'd2);
      if (i == 3) begin
        c_cmplt = 1'b1; c_rdata = 32'h0;
      end
      tick();
    end
    c_cmplt = 1'b0;
    chk("dly_cmplt", 32'(cmplt), 32'd1);
    chk("dly_err",   32'(error), 32'd0);
    chk("dly_sel_off", 32'(sel), 32'd0);
    tick();
    chk("dly_ready", 32'(ready), 32'd1);
    chk("dly_idle_sel", 32'(sel), 32'd0);
    tick();
    req = 1'b0;
    chk("held_sel",   32'(sel),     32'd1);
    chk("held_caddr", 32'(c_addr),  32'h0000_0010);
    chk("held_cwr",   32'(c_write), 32'd0);
    c_cmplt = 1'b1; c_rdata = 32'hCAFE_F00D;
    tick();
    c_cmplt = 1'b0;
    chk("held_cmplt", 32'(cmplt), 32'd1);
    chk("held_rdata", rdata,      32'hCAFE_F00D);
    tick();

    // responder never completes
    lsu(32'hE000_0020, 1'b0, 32'h0, 2'd2);
    tick();
    req = 1'b0;
`ifdef CR_TCIPIF_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_sel%0d", i), 32'(sel), 32'd1);
      tick();
    end
    chk("to_sel_off", 32'(sel),   32'd0);
    chk("to_cmplt",   32'(cmplt), 32'd1);
    chk("to_err",     32'(error), 32'd1);
    chk("to_rdata",   rdata,      32'd0);
    tick();
    chk("to_ready",   32'(ready), 32'd1);
`else
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("hang_sel%0d", i),   32'(sel),   32'd1);
      chk($sformatf("hang_cmplt%0d", i), 32'(cmplt), 32'd0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("hang_rst_sel",   32'(sel),   32'd0);
    chk("hang_rst_ready", 32'(ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    // asynchronous reset in REQ cycle 2
    lsu(32'hE000_0030, 1'b0, 32'h0, 2'd2);
    tick();
    req = 1'b0;
    chk("ar_sel1", 32'(sel), 32'd1);
    tick();
    chk("ar_sel2", 32'(sel), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_sel",   32'(sel),   32'd0);
    chk("ar_ready", 32'(ready), 32'd1);
    chk("ar_cmplt", 32'(cmplt), 32'd0);
    c_cmplt = 1'b1; c_rdata = 32'h7777_7777;
    tick();
    c_cmplt = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("ar_no_cmplt", 32'(cmplt), 32'd0);
    lsu(32'hE000_0004, 1'b0, 32'h0, 2'd2);
    tick();
    req = 1'b0;
    chk("post_sel",   32'(sel),    32'd1);
    chk("post_caddr", 32'(c_addr), 32'h0000_0004);
    c_cmplt = 1'b1; c_rdata = 32'h0BAD_F00D;
    tick();
    c_cmplt = 1'b0;
    chk("post_cmplt", 32'(cmplt), 32'd1);
    chk("post_rdata", rdata,      32'h0BAD_F00D);
    chk("post_err",   32'(error), 32'd0);
    tick();
    chk("post_ready", 32'(ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
